// File: rtl/cnn_tile_sched_pkg.sv
// Shared constants and state encoding for the CNNBuffer layer/tile scheduler.
// Field widths mirror the CNNBuffer configuration port widths.
package cnn_tile_sched_pkg;

  localparam int unsigned KernelWidth       = 4;
  localparam int unsigned BufferWidth       = 16;
  localparam int unsigned BufferDepth       = 16;
  localparam int unsigned StrideWidth       = 2;
  localparam int unsigned BwW               = $clog2(BufferWidth);
  localparam int unsigned BdW               = $clog2(BufferDepth);
  localparam int unsigned WdogCyclesDefault = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StDrain,
    StFinal,
    StNext,
    StDone
  } sched_state_e;

endpackage

// File: rtl/cnn_sched_wdog.sv
// Per-tile watchdog: counts enabled cycles since the last window and flags
// expiry on the cycle that would reach Cycles.
module cnn_sched_wdog #(
  parameter int unsigned Cycles = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic kick,
  output logic expire
);

  localparam int unsigned CntW = $clog2(Cycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || kick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A window arriving this cycle rescues the tile even at the limit.
  assign expire = en && !kick && !clr && (cnt_q == CntW'(Cycles - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cnn_tile_sched.sv
// Layer/tile scheduler: latches a layer descriptor, sequences req/req_final per
// tile for one CNNBuffer, counts windows and abandons hung tiles.
module cnn_tile_sched
  import cnn_tile_sched_pkg::*;
#(
  parameter int unsigned TILE_CNT_W  = 16,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WDOG_CYCLES = WdogCyclesDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [KernelWidth-1:0] cfg_kw,
  input  logic [KernelWidth-1:0] cfg_kh,
  input  logic [BwW-1:0]         cfg_bw,
  input  logic [BdW-1:0]         cfg_bd,
  input  logic [StrideWidth-1:0] cfg_stride,
  input  logic [TILE_CNT_W-1:0]  cfg_tiles,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [ADDR_W-1:0]      cfg_tile_step,
  output logic [KernelWidth-1:0] kernel_width_o,
  output logic [KernelWidth-1:0] kernel_height_o,
  output logic [BwW-1:0]         buffer_width_o,
  output logic [BdW-1:0]         buffer_depth_o,
  output logic [StrideWidth-1:0] stride_o,
  output logic                   buf_req,
  output logic                   buf_req_final,
  input  logic                   buf_window_valid,
  input  logic                   buf_window_finish,
  output logic                   buf_window_stall,
  input  logic                   pe_ready,
  input  logic                   abort,
  output logic [ADDR_W-1:0]      tile_addr,
  output logic [TILE_CNT_W-1:0]  tile_idx,
  output logic [31:0]            win_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   err_wdog
);

  sched_state_e           state_q, state_d;
  logic [KernelWidth-1:0] kw_q, kw_d, kh_q, kh_d;
  logic [BwW-1:0]         bw_q, bw_d;
  logic [BdW-1:0]         bd_q, bd_d;
  logic [StrideWidth-1:0] stride_q, stride_d;
  logic [TILE_CNT_W-1:0]  last_q, last_d, idx_q, idx_d;
  logic [ADDR_W-1:0]      step_q, step_d, addr_q, addr_d;
  logic [31:0]            win_q, win_d;
  logic                   req_q, req_d, fin_q, fin_d, done_q, done_d;
  logic                   err_q, err_d, guard_q, guard_d, abort_q, abort_d;
  logic                   in_win, wdog_expire;

  assign in_win = (state_q == StRun) || (state_q == StDrain);

  cnn_sched_wdog #(
    .Cycles(WDOG_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == StStart),
    .en    ((state_q == StRun) && pe_ready),
    .kick  (buf_window_valid),
    .expire(wdog_expire)
  );

  always_comb begin
    state_d  = state_q;
    kw_d     = kw_q;
    kh_d     = kh_q;
    bw_d     = bw_q;
    bd_d     = bd_q;
    stride_d = stride_q;
    last_d   = last_q;
    step_d   = step_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    win_d    = win_q;
    err_d    = err_q;
    abort_d  = abort_q;
    req_d    = 1'b0;
    fin_d    = 1'b0;
    done_d   = 1'b0;
    guard_d  = 1'b0;

    if (in_win && buf_window_valid && (win_q != '1)) begin
      win_d = win_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          kw_d     = cfg_kw;
          kh_d     = cfg_kh;
          bw_d     = cfg_bw;
          bd_d     = cfg_bd;
          stride_d = cfg_stride;
          last_d   = (cfg_tiles == '0) ? '0 : cfg_tiles - TILE_CNT_W'(1);
          step_d   = cfg_tile_step;
          addr_d   = cfg_base;
          idx_d    = '0;
          win_d    = '0;
          err_d    = 1'b0;
          abort_d  = 1'b0;
          req_d    = 1'b1;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (abort) begin
          abort_d = 1'b1;
          fin_d   = 1'b1;
          state_d = StFinal;
        end else begin
          guard_d = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // First RUN cycle still sees the buffer's finish flag from the last tile.
        if (abort) begin
          abort_d = 1'b1;
          fin_d   = 1'b1;
          state_d = StFinal;
        end else if (!guard_q && buf_window_finish) begin
          state_d = StDrain;
        end else if (wdog_expire) begin
          err_d   = 1'b1;
          fin_d   = 1'b1;
          state_d = StFinal;
        end
      end
      StDrain: begin
        if (abort) begin
          abort_d = 1'b1;
        end
        fin_d   = 1'b1;
        state_d = StFinal;
      end
      StFinal: begin
        if (abort_q) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (abort || (idx_q == last_q)) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + TILE_CNT_W'(1);
          addr_d  = addr_q + step_q;
          req_d   = 1'b1;
          state_d = StStart;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      kw_q     <= '0;
      kh_q     <= '0;
      bw_q     <= '0;
      bd_q     <= '0;
      stride_q <= '0;
      last_q   <= '0;
      step_q   <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      win_q    <= '0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      req_q    <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
      guard_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kw_q     <= kw_d;
      kh_q     <= kh_d;
      bw_q     <= bw_d;
      bd_q     <= bd_d;
      stride_q <= stride_d;
      last_q   <= last_d;
      step_q   <= step_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      win_q    <= win_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
      req_q    <= req_d;
      fin_q    <= fin_d;
      done_q   <= done_d;
      guard_q  <= guard_d;
    end
  end

  assign cfg_ready        = (state_q == StIdle);
  assign busy             = (state_q != StIdle);
  assign buf_window_stall = in_win ? ~pe_ready : 1'b1;
  assign kernel_width_o   = kw_q;
  assign kernel_height_o  = kh_q;
  assign buffer_width_o   = bw_q;
  assign buffer_depth_o   = bd_q;
  assign stride_o         = stride_q;
  assign buf_req          = req_q;
  assign buf_req_final    = fin_q;
  assign done             = done_q;
  assign err_wdog         = err_q;
  assign tile_addr        = addr_q;
  assign tile_idx         = idx_q;
  assign win_cnt          = win_q;

endmodule

// File: tb/tb_cnn_tile_sched.sv
// Scoreboard bench for cnn_tile_sched: a behavioural CNNBuffer model answers
// req pulses; expected req/req_final/done events are queued and checked by a monitor.
module tb_cnn_tile_sched;
  import cnn_tile_sched_pkg::*;

  localparam int unsigned TW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned WD = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_valid, cfg_ready;
  logic [KernelWidth-1:0] cfg_kw, cfg_kh, kw_o, kh_o;
  logic [BwW-1:0]         cfg_bw, bw_o;
  logic [BdW-1:0]         cfg_bd, bd_o;
  logic [StrideWidth-1:0] cfg_stride, stride_o;
  logic [TW-1:0]          cfg_tiles, tile_idx;
  logic [AW-1:0]          cfg_base, cfg_tile_step, tile_addr;
  logic                   buf_req, buf_req_final, buf_window_valid, buf_window_finish;
  logic                   buf_window_stall, pe_ready, abort, busy, done, err_wdog;
  logic [31:0]            win_cnt;

  always #5 clk = ~clk;

  cnn_tile_sched #(
    .TILE_CNT_W (TW),
    .ADDR_W     (AW),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_kw           (cfg_kw),
    .cfg_kh           (cfg_kh),
    .cfg_bw           (cfg_bw),
    .cfg_bd           (cfg_bd),
    .cfg_stride       (cfg_stride),
    .cfg_tiles        (cfg_tiles),
    .cfg_base         (cfg_base),
    .cfg_tile_step    (cfg_tile_step),
    .kernel_width_o   (kw_o),
    .kernel_height_o  (kh_o),
    .buffer_width_o   (bw_o),
    .buffer_depth_o   (bd_o),
    .stride_o         (stride_o),
    .buf_req          (buf_req),
    .buf_req_final    (buf_req_final),
    .buf_window_valid (buf_window_valid),
    .buf_window_finish(buf_window_finish),
    .buf_window_stall (buf_window_stall),
    .pe_ready         (pe_ready),
    .abort            (abort),
    .tile_addr        (tile_addr),
    .tile_idx         (tile_idx),
    .win_cnt          (win_cnt),
    .busy             (busy),
    .done             (done),
    .err_wdog         (err_wdog)
  );

  typedef struct {
    int          kind;  // 0 req, 1 req_final, 2 done
    logic [31:0] addr;
    int          idx;
    int          win;
    int          err;
    int          gap;   // cycles from req, 0 = unchecked
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  n_win = 0;
  bit  toggle_mode = 1'b0;
  int  cyc = 0;
  int  last_req_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input int idx, input int win,
                      input int err, input int gap);
    ev_t e;
    e.kind = kind; e.addr = addr; e.idx = idx; e.win = win; e.err = err; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Buffer model: finish rises with the last window issue, its valid lags one cycle,
  // and a stale finish is only cleared one edge after req.
  int   m_cnt;
  logic m_active, m_req_seen, m_pend;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_active <= 1'b0; m_req_seen <= 1'b0; m_pend <= 1'b0;
      buf_window_valid <= 1'b0; buf_window_finish <= 1'b0;
    end else begin
      m_req_seen       <= buf_req;
      buf_window_valid <= m_pend;
      if (m_req_seen) begin
        m_active <= 1'b1; m_cnt <= 0; buf_window_finish <= 1'b0; m_pend <= 1'b0;
      end else if (m_active && !buf_window_stall && m_cnt < n_win) begin
        m_cnt  <= m_cnt + 1;
        m_pend <= 1'b1;
        if (m_cnt + 1 == n_win) buf_window_finish <= 1'b1;
      end else begin
        m_pend <= 1'b0;
      end
      if (buf_req_final) m_active <= 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) pe_ready = ~pe_ready;
    end
  end

  task automatic check_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind", kind, e.kind);
    chk("ev_addr", tile_addr, e.addr);
    chk("ev_idx", tile_idx, e.idx);
    chk("ev_win", win_cnt, e.win);
    chk("ev_err", err_wdog, e.err);
    if (e.gap != 0) chk("ev_gap", cyc - last_req_cyc, e.gap);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (buf_req) begin
      last_req_cyc = cyc;
      check_ev(0);
    end
    if (buf_req_final) check_ev(1);
    if (done) check_ev(2);
  end

  task automatic expect_layer(input int tiles, input logic [31:0] base, input logic [31:0] step,
                              input int n, input int gap, input bit wdog);
    int t;
    t = (tiles == 0) ? 1 : tiles;
    for (int i = 0; i < t; i++) begin
      push(0, base + step * i, i, i * n, (wdog && i > 0) ? 1 : 0, 0);
      push(1, base + step * i, i, (i + 1) * n, wdog ? 1 : 0, wdog ? WD + 1 : gap);
    end
    push(2, base + step * (t - 1), t - 1, t * n, wdog ? 1 : 0, 0);
  endtask

  task automatic do_cfg(input int kw, input int kh, input int bw, input int bd, input int st,
                        input int tiles, input logic [31:0] base, input logic [31:0] step);
    @(negedge clk);
    cfg_kw = kw[KernelWidth-1:0]; cfg_kh = kh[KernelWidth-1:0];
    cfg_bw = bw[BwW-1:0]; cfg_bd = bd[BdW-1:0]; cfg_stride = st[StrideWidth-1:0];
    cfg_tiles = tiles[TW-1:0]; cfg_base = base; cfg_tile_step = step;
    cfg_valid = 1'b1;
    chk("cfg_ready_idle", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("kw_o", kw_o, kw);
    chk("kh_o", kh_o, kh);
    chk("bw_o", bw_o, bw);
    chk("bd_o", bd_o, bd);
    chk("stride_o", stride_o, st);
    chk("busy_after_cfg", busy, 1);
    chk("err_cleared", err_wdog, 0);
  endtask

  task automatic wait_done(input int exp_win);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    chk("win_hold", win_cnt, exp_win);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0; pe_ready = 1'b1;
    cfg_kw = '0; cfg_kh = '0; cfg_bw = '0; cfg_bd = '0; cfg_stride = '0;
    cfg_tiles = '0; cfg_base = '0; cfg_tile_step = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", buf_req, 0);
    chk("rst_req_final", buf_req_final, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_wdog, 0);
    chk("rst_stall", buf_window_stall, 1);
    chk("rst_addr", tile_addr, 0);
    chk("rst_idx", tile_idx, 0);
    chk("rst_win", win_cnt, 0);
    chk("rst_kw_o", kw_o, 0);

    // Single tile, 36 windows back to back.
    n_win = 36;
    expect_layer(1, 32'h0, 32'h0, 36, 40, 1'b0);
    do_cfg(3, 3, 7, 7, 1, 1, 32'h0, 32'h0);
    wait_done(36);

    // Three tiles; tiles 1 and 2 start with the buffer's finish still high.
    expect_layer(3, 32'h1000, 32'h200, 36, 40, 1'b0);
    do_cfg(3, 3, 7, 7, 1, 3, 32'h1000, 32'h200);
    wait_done(108);

    // PE backpressure every other cycle.
    toggle_mode = 1'b1;
    expect_layer(1, 32'h80, 32'h0, 36, 0, 1'b0);
    do_cfg(3, 3, 7, 7, 1, 1, 32'h80, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall_mirror", buf_window_stall, !pe_ready);
    end
    wait_done(36);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_idle", buf_window_stall, 1);
    end
    toggle_mode = 1'b0;
    pe_ready = 1'b1;

    // Hung buffer: no windows, watchdog abandons each tile.
    n_win = 0;
    expect_layer(2, 32'h3000, 32'h40, 0, 0, 1'b1);
    do_cfg(3, 3, 7, 7, 1, 2, 32'h3000, 32'h40);
    wait_done(0);
    chk("err_sticky", err_wdog, 1);

    // Abort in RUN of tile 1 of 4.
    n_win = 8;
    push(0, 32'h2000, 0, 0, 0, 0);
    push(1, 32'h2000, 0, 8, 0, 12);
    push(0, 32'h2010, 1, 8, 0, 0);
    push(1, 32'h2010, 1, 8, 0, 3);
    push(2, 32'h2010, 1, 8, 0, 0);
    do_cfg(3, 3, 7, 7, 1, 4, 32'h2000, 32'h10);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(negedge clk);
        if (buf_req && tile_idx == 1) hit = 1'b1;
      end
      chk("tile1_start_seen", hit, 1);
    end
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(8);
    chk("abort_idx", tile_idx, 1);

    // New layer after abort; zero tiles means one tile.
    n_win = 4;
    expect_layer(0, 32'hFFFF_FFF0, 32'h20, 4, 8, 1'b0);
    do_cfg(5, 2, 15, 3, 2, 0, 32'hFFFF_FFF0, 32'h20);
    wait_done(4);

    // Reset mid-layer: no req_final may follow.
    n_win = 36;
    push(0, 32'h5000, 0, 0, 0, 0);
    do_cfg(3, 3, 7, 7, 1, 2, 32'h5000, 32'h100);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cfg_ready, 1);
    chk("midrst_win", win_cnt, 0);
    chk("midrst_stall", buf_window_stall, 1);
    repeat (50) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
